// File: rtl/scr1_imem_instr_classifier.sv
// Classifies imem fetch beats into instruction classes, queues selected events
// in a small FIFO and keeps saturating statistics counters.
module scr1_imem_instr_classifier #(
  parameter int unsigned EVT_DEPTH = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       imem_resp,
  input  logic [31:0]      imem_rdata,
  input  logic [7:0]       evt_mask,
  input  logic             cnt_clr,
  input  logic             evt_pop,
  output logic             evt_valid,
  output logic [2:0]       evt_class,
  output logic [31:0]      evt_instr,
  output logic             evt_ovf,
  output logic [CNT_W-1:0] cnt_okay,
  output logic [CNT_W-1:0] cnt_and,
  output logic [CNT_W-1:0] cnt_err
);

  localparam int unsigned AW = $clog2(EVT_DEPTH);

  localparam logic [1:0] RESP_OKAY = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] CLS_OTHER  = 3'd0;
  localparam logic [2:0] CLS_AND    = 3'd1;
  localparam logic [2:0] CLS_ANDI   = 3'd2;
  localparam logic [2:0] CLS_OP     = 3'd3;
  localparam logic [2:0] CLS_LOAD   = 3'd4;
  localparam logic [2:0] CLS_STORE  = 3'd5;
  localparam logic [2:0] CLS_BRANCH = 3'd6;
  localparam logic [2:0] CLS_ERR    = 3'd7;

  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic          beat_okay;
  logic          beat_err;
  logic          beat;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [2:0]    cls;
  logic          is_and;

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          drop;

  logic [2:0]    mem_class [EVT_DEPTH];
  logic [31:0]   mem_instr [EVT_DEPTH];

  assign beat_okay = (imem_resp == RESP_OKAY);
  assign beat_err  = (imem_resp == RESP_ERR);
  assign beat      = beat_okay | beat_err;

  assign opcode = imem_rdata[6:0];
  assign funct3 = imem_rdata[14:12];
  assign funct7 = imem_rdata[31:25];

  always_comb begin
    cls = CLS_OTHER;
    if (beat_err) begin
      cls = CLS_ERR;
    end else begin
      unique case (opcode)
        OPC_OP:     cls = (funct3 == 3'b111 && funct7 == 7'b0000000) ? CLS_AND : CLS_OP;
        OPC_IMM:    cls = (funct3 == 3'b111) ? CLS_ANDI : CLS_OTHER;
        OPC_LOAD:   cls = CLS_LOAD;
        OPC_STORE:  cls = CLS_STORE;
        OPC_BRANCH: cls = CLS_BRANCH;
        default:    cls = CLS_OTHER;
      endcase
    end
  end

  assign is_and = beat_okay && (cls == CLS_AND);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = beat && evt_mask[cls];
  assign pop   = evt_pop && !empty;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_class[wr_ptr[AW-1:0]] <= cls;
      mem_instr[wr_ptr[AW-1:0]] <= beat_err ? '0 : imem_rdata;
    end
  end

  assign evt_valid = !empty;
  assign evt_class = empty ? '0 : mem_class[rd_ptr[AW-1:0]];
  assign evt_instr = empty ? '0 : mem_instr[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_ovf <= 1'b0;
    end else if (cnt_clr) begin
      evt_ovf <= 1'b0;
    end else if (drop) begin
      evt_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_okay <= '0;
      cnt_and  <= '0;
      cnt_err  <= '0;
    end else if (cnt_clr) begin
      cnt_okay <= '0;
      cnt_and  <= '0;
      cnt_err  <= '0;
    end else begin
      if (beat_okay && cnt_okay != '1) cnt_okay <= cnt_okay + CNT_ONE;
      if (is_and && cnt_and != '1)     cnt_and  <= cnt_and + CNT_ONE;
      if (beat_err && cnt_err != '1)   cnt_err  <= cnt_err + CNT_ONE;
    end
  end

endmodule
